// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the register file debug/dump logic.
//   REG_ADDR_W : register index width (32 registers)
//   DATA_W     : register data width
//   NUM_REGS   : number of architectural registers
//   LAT_CNT_W  : width of the read-latency counter (holds READ_LAT up to 4)
//   state_t    : dump reader states
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int LAT_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

endpackage

// File: rtl/rd_lat_counter.sv
// -----------------------------------------------------------------------------
// rd_lat_counter
// Loadable down-counter modelling register file read latency. Loaded with the
// latency when a new read address is presented; decremented while enabled.
// capture is high in the cycle whose closing edge must sample the read data.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   load     in   load load_val (priority over en)
//   load_val in   latency value to load
//   en       in   decrement enable (saturates at zero)
//   capture  out  count equals one: read data is valid at the next edge
// -----------------------------------------------------------------------------
module rd_lat_counter
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LAT_CNT_W-1:0] load_val,
    input  logic                 en,
    output logic                 capture
);

    logic [LAT_CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign capture = (cnt == LAT_CNT_W'(1));

endmodule

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Debug reader for the 32x32 register file. A start pulse in IDLE walks
// registers FIRST_REG..LAST_REG through read port 1, captures each value
// READ_LAT cycles after the address is presented and streams it out as
// (dout_addr, dout, dout_last) over a valid/ready handshake. While busy is high
// this block owns rf_a1; the core must keep its own read mux off that port.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a dump (only honoured in IDLE)
//   rf_a1      out  register file read address 1
//   rf_rd1     in   register file read data 1
//   dout       out  captured register value
//   dout_addr  out  register index of dout
//   dout_valid out  output word valid
//   dout_ready in   sink accepts the word
//   dout_last  out  word belongs to LAST_REG
//   busy       out  dump in progress
//   done       out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module regfile_dump_reader
    import mips_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] rf_a1,
    input  logic [DATA_W-1:0]     rf_rd1,
    output logic [DATA_W-1:0]     dout,
    output logic [REG_ADDR_W-1:0] dout_addr,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  done
);

    generate
        if ((FIRST_REG < 0) || (FIRST_REG > LAST_REG) || (LAST_REG > NUM_REGS - 1) ||
            (READ_LAT < 1) || (READ_LAT > 4)) begin : g_param_check
            $error("regfile_dump_reader: need 0<=FIRST_REG<=LAST_REG<=31 and 1<=READ_LAT<=4");
        end
    endgenerate

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);
    localparam logic [LAT_CNT_W-1:0]  LAT_V   = LAT_CNT_W'(READ_LAT);

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  done_q, done_d;
    logic                  cnt_load, cnt_en, capture;
    logic                  is_last;

    rd_lat_counter u_rd_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_V),
        .en       (cnt_en),
        .capture  (capture)
    );

    assign is_last = (addr_q == LAST_A);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= FIRST_A;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave a variable unassigned and infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WAIT;
                    addr_d   = FIRST_A;
                    cnt_load = 1'b1;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (capture) begin
                    data_d  = rf_rd1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (dout_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Increment only below LAST_REG, so the index never wraps.
                        addr_d   = addr_q + REG_ADDR_W'(1);
                        cnt_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rf_a1      = addr_q;
    assign dout       = data_q;
    assign dout_addr  = addr_q;
    assign dout_valid = (state_q == SEND);
    assign dout_last  = (state_q == SEND) && is_last;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/verification reader for the 32x32 register file.
- On a start pulse it walks a contiguous register range through one read port (A1/RD1), captures each value after a fixed read latency, and streams it out over a valid/ready interface as (address, data, last).
- It sits beside the register file and owns the A1 address while busy.
- The core must hold the read mux off A1 while busy is high.

Parameters:
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31).
- READ_LAT, 1: cycles from rf_a1 change to valid rf_rd1 (1..4).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a dump; sampled only in IDLE
- rf_a1  out  5  register file read address 1
- rf_rd1  in  32  register file read data 1
- dout  out  32  captured register value
- dout_addr  out  5  index of the register in dout
- dout_valid  out  1  dout/dout_addr/dout_last valid
- dout_ready  in  1  sink accepts the word when high with dout_valid
- dout_last  out  1  high with the word for LAST_REG
- busy  out  1  high from the start acceptance edge until the final handshake edge
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: rst_n low at a rising edge sets the following:
  - state=IDLE, addr_q=FIRST_REG, cnt=0, data_q=0;
  - dout_valid=0, dout_last=0, busy=0, done=0.
  - Reset has priority over every other input, including mid-dump; no partial word is emitted after it.
- Output mapping: rf_a1=addr_q at all times; dout=data_q; dout_addr=addr_q.
- IDLE:
  - start=1 at an edge sets addr_q=FIRST_REG, cnt=READ_LAT, goes to WAIT, busy=1.
  - start is ignored in every other state.
- WAIT:
  - Each edge decrements cnt.
  - At the edge where cnt==1: data_q<=rf_rd1 and go to SEND.
- SEND:
  - dout_valid=1; dout_last=(addr_q==LAST_REG).
  - Outputs stay stable until dout_valid&&dout_ready is high at an edge.
  - Handshake with addr_q!=LAST_REG: addr_q<=addr_q+1, cnt<=READ_LAT, go to WAIT.
  - Handshake with addr_q==LAST_REG: go to IDLE, busy<=0, done<=1 for exactly one cycle.
  - dout_ready while not valid has no effect.
- Timing with READ_LAT=1 and ready held high: 2 cycles per word; a full 32-register dump takes 64 cycles from the start edge to the final handshake edge.
- Address never wraps past 31; addr_q only increments while addr_q<LAST_REG.
- start high on the same edge as the done pulse is ignored, because the state is still SEND at that edge; a start in the following IDLE cycle is accepted.
- FIRST_REG==LAST_REG: single word with dout_last=1.
- Register writes landing during a dump are not blocked. The captured value is whatever rf_rd1 shows at the capture edge.

Decomposition:
- Shared package (mips_pkg):
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32;
  - state enum {IDLE, WAIT, SEND}.
- One sub-module is natural: rd_lat_counter, a loadable down-counter that flags the capture cycle, reused wherever read latency is modelled.
- Elaboration-time check: FIRST_REG<=LAST_REG<=31 and 1<=READ_LAT<=4.

Test Plan:
- Preload reg[i]=32'hA000_0000+i, ready=1, pulse start: 32 words, addr 0..31, data A0000000..A000001F, dout_last only on addr 31, done one cycle after edge 64, busy low afterwards.
- Same preload with dout_ready toggled pseudo-randomly: dout/addr held stable while valid&&!ready; no word dropped or duplicated; order unchanged.
- FIRST_REG=5, LAST_REG=5, reg[5]=32'hDEAD_BEEF: exactly one word 0xDEADBEEF at addr 5 with dout_last=1 and done.
- READ_LAT=3 with a bench regfile delaying rd1 by 3 cycles: values correct; 4 cycles per word with ready high.
- rst_n low for one edge while in SEND at addr 10: next cycle all outputs are reset values; a new start restarts at FIRST_REG.
- start pulsed repeatedly during a dump: ignored, single dump only. A start one cycle after done launches a second full dump.
